ntt_addr_gen: RTL and testbench

- Control and address sequencer for an in-place 256-point NTT.
- Sits directly upstream of the 4-port, 256x16 coefficient RAM. It drives the RAM's four address ports and its write enable, which selects between a read and a write.
- Issues two radix-2 butterflies per RAM access: one read, then a write-back of the butterfly results to the same addresses.
- Also emits twiddle-ROM indices and a data-valid strobe to the butterfly pipeline between RAM read and write.

---
 rtl/ntt_addr_gen.sv | 218 +++++++++++++++++++++
 tb/tb_ntt_addr_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: address/control sequencer for an in-place 256-point NTT.
// Each pair issues two radix-2 butterflies: one RAM read, BF_LAT wait
// cycles while the butterfly pipeline computes, then a write-back to the
// same four addresses. Every output is registered.
// Optional macro NTT_GS_EN adds the 'inv' input, which selects
// Gentleman-Sande stage order (len = 1 << s) for the inverse transform.
module ntt_addr_gen #(
  parameter int BF_LAT = 2,
  parameter int LOGN   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef NTT_GS_EN
  input  logic            inv,
`endif
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [LOGN-1:0] A1radd,
  output logic [LOGN-1:0] B1radd,
  output logic [LOGN-1:0] A2radd,
  output logic [LOGN-1:0] B2radd,
  output logic [LOGN-1:0] tw1_idx,
  output logic [LOGN-1:0] tw2_idx,
  output logic            rd_valid
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } state_t;

  // Last value of the wait counter; clamped so a zero-latency build still
  // has a legal constant even though WAIT is never entered then.
  localparam logic [3:0] LP_WAIT_LAST = (BF_LAT == 0) ? 4'd0 : 4'(BF_LAT - 1);

  state_t          r_state;
  logic [2:0]      r_s;
  logic [5:0]      r_p;
  logic [3:0]      r_wait;
  logic            r_busy;
  logic            r_done;
  logic            r_we;
  logic            r_rdValid;
  logic [LOGN-1:0] r_a1;
  logic [LOGN-1:0] r_b1;
  logic [LOGN-1:0] r_a2;
  logic [LOGN-1:0] r_b2;
  logic [LOGN-1:0] r_tw1;
  logic [LOGN-1:0] r_tw2;
`ifdef NTT_GS_EN
  logic            r_inv;
`endif

  logic [2:0]      w_nextS;
  logic [5:0]      w_nextP;
  logic            w_nextInv;
  logic            w_lastPair;
  logic [2:0]      w_sh;
  logic [LOGN-1:0] w_a1;
  logic [LOGN-1:0] w_b1;
  logic [LOGN-1:0] w_a2;
  logic [LOGN-1:0] w_b2;
  logic [LOGN-1:0] w_tw1;
  logic [LOGN-1:0] w_tw2;

  // Butterfly k with half-span 2**sh: group = k >> sh, j = k mod 2**sh,
  // a = group*2*len + j, b = a + len, tw = 128/len + group.
  function automatic logic [23:0] bfAddr(input logic [7:0] k, input logic [2:0] sh);
    logic [7:0] lenV;
    logic [7:0] grp;
    logic [7:0] j;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] tw;
    lenV = 8'd1 << sh;
    grp  = k >> sh;
    j    = k & (lenV - 8'd1);
    a    = (grp << ({1'b0, sh} + 4'd1)) + j;
    b    = a + lenV;
    tw   = (8'd128 >> sh) + grp;
    return {a, b, tw};
  endfunction

`ifdef NTT_GS_EN
  // In IDLE the direction comes straight from the port so the first pair
  // already uses the order being latched.
  assign w_nextInv = (r_state == ST_IDLE) ? inv : r_inv;
`else
  assign w_nextInv = 1'b0;
`endif

  // Stage/pair counters for the pair about to be issued (fresh start or step).
  always_comb begin
    w_nextS    = r_s;
    w_nextP    = r_p + 6'd1;
    w_lastPair = (r_p == 6'd63) && (r_s == 3'd7);
    if (r_state == ST_IDLE) begin
      w_nextS = 3'd0;
      w_nextP = 6'd0;
    end else if (r_p == 6'd63) begin
      w_nextS = r_s + 3'd1;
      w_nextP = 6'd0;
    end
  end

  // Addresses and twiddles of the next pair, loaded on entry to RD.
  always_comb begin
    w_sh = w_nextInv ? w_nextS : (3'd7 - w_nextS);
    {w_a1, w_b1, w_tw1} = bfAddr({1'b0, w_nextP, 1'b0}, w_sh);
    {w_a2, w_b2, w_tw2} = bfAddr({1'b0, w_nextP, 1'b1}, w_sh);
  end

  // Sequencer FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_s       <= 3'd0;
      r_p       <= 6'd0;
      r_wait    <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_we      <= 1'b0;
      r_rdValid <= 1'b0;
      r_a1      <= '0;
      r_b1      <= '0;
      r_a2      <= '0;
      r_b2      <= '0;
      r_tw1     <= '0;
      r_tw2     <= '0;
`ifdef NTT_GS_EN
      r_inv     <= 1'b0;
`endif
    end else begin
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_rdValid <= (r_state == ST_RD);
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_s     <= w_nextS;
            r_p     <= w_nextP;
            r_a1    <= w_a1;
            r_b1    <= w_b1;
            r_a2    <= w_a2;
            r_b2    <= w_b2;
            r_tw1   <= w_tw1;
            r_tw2   <= w_tw2;
            r_busy  <= 1'b1;
            r_state <= ST_RD;
`ifdef NTT_GS_EN
            r_inv   <= inv;
`endif
          end
        end
        ST_RD: begin
          r_wait <= 4'd0;
          if (BF_LAT == 0) begin
            r_we    <= 1'b1;
            r_state <= ST_WR;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_wait == LP_WAIT_LAST) begin
            r_we    <= 1'b1;
            r_state <= ST_WR;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        ST_WR: begin
          if (w_lastPair) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_s     <= w_nextS;
            r_p     <= w_nextP;
            r_a1    <= w_a1;
            r_b1    <= w_b1;
            r_a2    <= w_a2;
            r_b2    <= w_b2;
            r_tw1   <= w_tw1;
            r_tw2   <= w_tw2;
            r_state <= ST_RD;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign we       = r_we;
  assign rd_valid = r_rdValid;
  assign A1radd   = r_a1;
  assign B1radd   = r_b1;
  assign A2radd   = r_a2;
  assign B2radd   = r_b2;
  assign tw1_idx  = r_tw1;
  assign tw2_idx  = r_tw2;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// tb_ntt_addr_gen: directed bench for ntt_addr_gen (BF_LAT=2). With
// NTT_GS_EN defined a second instance (BF_LAT=0) covers inverse order.
module tb_ntt_addr_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       we;
  logic [7:0] A1radd;
  logic [7:0] B1radd;
  logic [7:0] A2radd;
  logic [7:0] B2radd;
  logic [7:0] tw1_idx;
  logic [7:0] tw2_idx;
  logic       rd_valid;

  int checks;
  int failures;
  int addrErr;
  int ctrlErr;

  ntt_addr_gen #(.BF_LAT(2), .LOGN(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef NTT_GS_EN
    .inv      (1'b0),
`endif
    .busy     (busy),
    .done     (done),
    .we       (we),
    .A1radd   (A1radd),
    .B1radd   (B1radd),
    .A2radd   (A2radd),
    .B2radd   (B2radd),
    .tw1_idx  (tw1_idx),
    .tw2_idx  (tw2_idx),
    .rd_valid (rd_valid)
  );

`ifdef NTT_GS_EN
  logic       start0;
  logic       busy0;
  logic       done0;
  logic       we0;
  logic [7:0] A1radd0;
  logic [7:0] B1radd0;
  logic [7:0] A2radd0;
  logic [7:0] B2radd0;
  logic [7:0] tw1Idx0;
  logic [7:0] tw2Idx0;
  logic       rdValid0;

  ntt_addr_gen #(.BF_LAT(0), .LOGN(8)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start0),
    .inv      (1'b1),
    .busy     (busy0),
    .done     (done0),
    .we       (we0),
    .A1radd   (A1radd0),
    .B1radd   (B1radd0),
    .A2radd   (A2radd0),
    .B2radd   (B2radd0),
    .tw1_idx  (tw1Idx0),
    .tw2_idx  (tw2Idx0),
    .rd_valid (rdValid0)
  );
`endif

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives the reset and start inputs.
  task automatic applyStimulus(input logic rstVal, input logic startVal);
    rst   = rstVal;
    start = startVal;
  endtask

  // Advances one clock and samples just after the edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference addresses straight from the division/modulo definition.
  task automatic expectPair(input int s, input int p, input int inv,
                            output int a1, output int b1, output int a2,
                            output int b2, output int t1, output int t2);
    int len;
    int k;
    int grp;
    len = inv ? (1 << s) : (128 >> s);
    k   = 2 * p;
    grp = k / len;
    a1  = grp * 2 * len + (k % len);
    b1  = a1 + len;
    t1  = 128 / len + grp;
    k   = 2 * p + 1;
    grp = k / len;
    a2  = grp * 2 * len + (k % len);
    b2  = a2 + len;
    t2  = 128 / len + grp;
  endtask

  initial begin
    int ea1, eb1, ea2, eb2, et1, et2;
    checks   = 0;
    failures = 0;
    addrErr  = 0;
    ctrlErr  = 0;
`ifdef NTT_GS_EN
    start0 = 1'b0;
`endif
    applyStimulus(1'b0, 1'b0);
    repeat (3) nextCycle();
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstWe", int'(we), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstRdValid", int'(rd_valid), 0);
    checkOutput("rstB1", int'(B1radd), 0);
    checkOutput("rstTw1", int'(tw1_idx), 0);

    applyStimulus(1'b1, 1'b0);
    nextCycle();
    checkOutput("idleBusy", int'(busy), 0);
    applyStimulus(1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0);

    // First RD cycle is c=0; pair period is 4 cycles with BF_LAT=2.
    checkOutput("rd0A1", int'(A1radd), 0);
    checkOutput("rd0B1", int'(B1radd), 128);
    checkOutput("rd0A2", int'(A2radd), 1);
    checkOutput("rd0B2", int'(B2radd), 129);
    checkOutput("rd0Tw1", int'(tw1_idx), 1);
    checkOutput("rd0Tw2", int'(tw2_idx), 1);
    checkOutput("rd0We", int'(we), 0);
    checkOutput("rd0Busy", int'(busy), 1);

    for (int c = 0; c < 2048; c++) begin
      int n;
      int ph;
      n  = c / 4;
      ph = c % 4;
      expectPair(n / 64, n % 64, 0, ea1, eb1, ea2, eb2, et1, et2);
      if (int'(A1radd) != ea1 || int'(B1radd) != eb1 || int'(A2radd) != ea2 ||
          int'(B2radd) != eb2 || int'(tw1_idx) != et1 || int'(tw2_idx) != et2)
        addrErr++;
      if (int'(we) != int'(ph == 3) || int'(rd_valid) != int'(ph == 1) ||
          busy != 1'b1 || done != 1'b0)
        ctrlErr++;
      if (c == 1) checkOutput("rd0ValidNext", int'(rd_valid), 1);
      if (c == 3) begin
        checkOutput("wr0We", int'(we), 1);
        checkOutput("wr0B2", int'(B2radd), 129);
      end
      if (c == (64 + 31) * 4) begin
        checkOutput("s1p31A1", int'(A1radd), 62);
        checkOutput("s1p31B1", int'(B1radd), 126);
        checkOutput("s1p31A2", int'(A2radd), 63);
        checkOutput("s1p31B2", int'(B2radd), 127);
        checkOutput("s1p31Tw", int'(tw2_idx), 2);
      end
      if (c == (64 + 32) * 4) begin
        checkOutput("s1p32A1", int'(A1radd), 128);
        checkOutput("s1p32B1", int'(B1radd), 192);
        checkOutput("s1p32B2", int'(B2radd), 193);
        checkOutput("s1p32Tw1", int'(tw1_idx), 3);
      end
      if (c == 448 * 4) begin
        checkOutput("s7p0A1", int'(A1radd), 0);
        checkOutput("s7p0B1", int'(B1radd), 1);
        checkOutput("s7p0A2", int'(A2radd), 2);
        checkOutput("s7p0B2", int'(B2radd), 3);
        checkOutput("s7p0Tw1", int'(tw1_idx), 128);
        checkOutput("s7p0Tw2", int'(tw2_idx), 129);
      end
      if (c == 511 * 4) begin
        checkOutput("s7p63A1", int'(A1radd), 252);
        checkOutput("s7p63B2", int'(B2radd), 255);
        checkOutput("s7p63Tw1", int'(tw1_idx), 254);
        checkOutput("s7p63Tw2", int'(tw2_idx), 255);
      end
      // start during a WAIT cycle must be ignored; start held from the last
      // WR through DONE must only re-trigger from IDLE.
      if (c == 5) applyStimulus(1'b1, 1'b1);
      if (c == 6) applyStimulus(1'b1, 1'b0);
      if (c == 2047) applyStimulus(1'b1, 1'b1);
      nextCycle();
    end
    checkOutput("addrModel", addrErr, 0);
    checkOutput("ctrlModel", ctrlErr, 0);

    checkOutput("doneAt2048", int'(done), 1);
    checkOutput("doneBusy", int'(busy), 0);
    checkOutput("doneWe", int'(we), 0);
    checkOutput("doneHoldA1", int'(A1radd), 252);
    checkOutput("doneHoldTw2", int'(tw2_idx), 255);
    nextCycle();
    checkOutput("idleAfterDoneBusy", int'(busy), 0);
    checkOutput("idleAfterDoneDone", int'(done), 0);
    checkOutput("idleHoldB2", int'(B2radd), 255);
    nextCycle();
    applyStimulus(1'b1, 1'b0);
    checkOutput("retrigBusy", int'(busy), 1);
    checkOutput("retrigB1", int'(B1radd), 128);

    // Run into stage 3 and reset during its first WAIT cycle.
    repeat (192 * 4 + 1) nextCycle();
    checkOutput("s3WaitBusy", int'(busy), 1);
    checkOutput("s3WaitB1", int'(B1radd), 16);
    checkOutput("s3WaitTw1", int'(tw1_idx), 8);
    checkOutput("s3WaitRdValid", int'(rd_valid), 1);
    applyStimulus(1'b0, 1'b0);
    #1;
    checkOutput("asyncRstBusy", int'(busy), 0);
    checkOutput("asyncRstRdValid", int'(rd_valid), 0);
    checkOutput("asyncRstB1", int'(B1radd), 0);
    checkOutput("asyncRstA2", int'(A2radd), 0);
    checkOutput("asyncRstTw1", int'(tw1_idx), 0);
    #3;
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    checkOutput("postRstIdle", int'(busy), 0);
    applyStimulus(1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0);
    checkOutput("restartA1", int'(A1radd), 0);
    checkOutput("restartB1", int'(B1radd), 128);
    checkOutput("restartTw1", int'(tw1_idx), 1);
    checkOutput("restartBusy", int'(busy), 1);

`ifdef NTT_GS_EN
    addrErr = 0;
    ctrlErr = 0;
    start0 = 1'b1;
    nextCycle();
    start0 = 1'b0;
    checkOutput("gsRd0A1", int'(A1radd0), 0);
    checkOutput("gsRd0B1", int'(B1radd0), 1);
    checkOutput("gsRd0A2", int'(A2radd0), 2);
    checkOutput("gsRd0B2", int'(B2radd0), 3);
    checkOutput("gsRd0Tw1", int'(tw1Idx0), 128);
    checkOutput("gsRd0Tw2", int'(tw2Idx0), 129);
    for (int c = 0; c < 1024; c++) begin
      int n;
      n = c / 2;
      expectPair(n / 64, n % 64, 1, ea1, eb1, ea2, eb2, et1, et2);
      if (int'(A1radd0) != ea1 || int'(B1radd0) != eb1 || int'(A2radd0) != ea2 ||
          int'(B2radd0) != eb2 || int'(tw1Idx0) != et1 || int'(tw2Idx0) != et2)
        addrErr++;
      if (int'(we0) != (c % 2) || int'(rdValid0) != (c % 2) ||
          busy0 != 1'b1 || done0 != 1'b0)
        ctrlErr++;
      if (c == 1022) begin
        checkOutput("gsLastA1", int'(A1radd0), 126);
        checkOutput("gsLastB1", int'(B1radd0), 254);
        checkOutput("gsLastA2", int'(A2radd0), 127);
        checkOutput("gsLastB2", int'(B2radd0), 255);
        checkOutput("gsLastTw1", int'(tw1Idx0), 1);
        checkOutput("gsLastTw2", int'(tw2Idx0), 1);
      end
      nextCycle();
    end
    checkOutput("gsAddrModel", addrErr, 0);
    checkOutput("gsCtrlModel", ctrlErr, 0);
    checkOutput("gsDoneAt1024", int'(done0), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
